proj_gfm_collector: RTL and testbench
=====================================

// Module: proj_gfm_collector
// PURPOSE
// - Downstream of the k-mer extender stage. Consumes its free-running stream of (signed index, FRAG_PART-bit fragment chunk) beats.
// - Reassembles FRAG_LEN/FRAG_PART consecutive chunks into one full fragment and clamps negative start indices.
// - Buffers completed groups in a small FIFO and presents them on a valid/ready output to the comparison stage.
// PARAMETERS
// - FRAG_LEN          8   fragment width in bits; must be a multiple of FRAG_PART
// - FRAG_PART         2   chunk width per input beat
// - INDICE_LEN        5   unsigned index width on the output
// - SIGNED_INDICE_LEN INDICE_LEN+1   signed index width on the input
// - FIFO_DEPTH        4   completed-group buffer depth; power of 2, >= 2
// PORTS
// - clk            in   1                  clock, rising edge
// - rst_n          in   1                  reset, asynchronous, active-low
// - in_valid       in   1                  input beat valid; no backpressure, every valid beat is consumed
// - in_index       in   SIGNED_INDICE_LEN  signed start index of the current group (two's complement)
// - in_gfm         in   FRAG_PART          fragment chunk
// - out_valid      out  1                  FIFO head valid
// - out_ready      in   1                  consumer accepts head
// - out_index      out  INDICE_LEN         clamped start index
// - out_fragment   out  FRAG_LEN           reassembled fragment
// - out_clipped    out  1                  in_index was negative and clamped to 0
// - err_overflow   out  1                  sticky: a completed group was dropped because the FIFO was full
// - err_mismatch   out  1                  sticky: in_index changed inside a group
// BEHAVIOUR
// - Reset (async assert, sync release): chunk counter = 0, FIFO empty.
//   All outputs are 0: out_valid, out_index, out_fragment, out_clipped, err_*.
// - NPARTS = FRAG_LEN/FRAG_PART. A beat is accepted when in_valid=1.
//   Cycles with in_valid=0 hold the counter and partial data.
// - Chunk k of a group (k = 0..NPARTS-1) is written to assembly bits [FRAG_PART*k +: FRAG_PART], LSB first.
// - in_index is captured on chunk 0.
//   On chunks 1..NPARTS-1, if in_index differs from the captured value:
//   - the partial group is discarded and err_mismatch is set;
//   - the current beat becomes chunk 0 of a new group.
// - Group completes on the beat with k = NPARTS-1. The counter wraps to 0 and a FIFO push is requested.
// - Clamp: captured index < 0 -> out_index 0, out_clipped 1.
//   Otherwise out_index = captured[INDICE_LEN-1:0], out_clipped 0.
// - Latency: out_valid rises the cycle after the completing beat when the FIFO was empty.
//   The FIFO is first-word-fall-through with registered outputs.
// - Pop occurs when out_valid & out_ready. The head holds stable while out_valid & ~out_ready.
// - Push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
//   Otherwise the group is dropped and err_overflow is set. Stored entries are unaffected.
// - Push and pop on an empty FIFO: no pop (out_valid=0). The new entry appears next cycle.
// - err_* bits are sticky until reset.
// - Reset mid-group: the partial group and all FIFO contents are lost.
//   The next accepted beat is chunk 0.
// STRUCTURE
// - proj_pkg additions:
//   - localparam function for NPARTS/$clog2 widths;
//   - typedef struct packed gfm_group_t {clipped, index, fragment}.
// - Sub-module proj_sync_fifo (parameterised width/depth, FWFT, full/empty, async active-low reset) stores gfm_group_t.
// - The collector owns the chunk counter, assembly register, index capture, clamp and error flags.
// TESTING (defaults: NPARTS=4)
// - Basic group: index 5, chunks 01,10,11,00 -> next cycle out_valid=1, out_fragment=0x39, out_index=5, out_clipped=0.
// - Negative index: index -2 with any 4 chunks -> out_index=0, out_clipped=1, fragment intact.
// - Overflow: out_ready=0, 5 groups -> 4 held, 5th dropped, err_overflow=1.
//   Then out_ready=1 -> the 4 groups drain in order and out_valid falls.
// - Mismatch: index 3 for 2 beats, then index 4 for 4 beats -> err_mismatch=1; exactly one group out with index 4.
// - Simultaneous: FIFO full, out_ready=1 on the completing-beat cycle -> push accepted, count stays 4, err_overflow=0.
// - Reset mid-group: rst_n low after 2 chunks -> out_valid=0 immediately.
//   After release, 4 beats (index 7) -> one group, index 7.

Source files
------------

// File: rtl/proj_pkg.sv
// Shared types and sizing helpers for the GFM collector slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: default widths, NPARTS / counter-width helpers, gfm_group_t.
package proj_pkg;

  localparam int DEF_FRAG_LEN          = 8;
  localparam int DEF_FRAG_PART         = 2;
  localparam int DEF_INDICE_LEN        = 5;
  localparam int DEF_SIGNED_INDICE_LEN = DEF_INDICE_LEN + 1;
  localparam int DEF_FIFO_DEPTH        = 4;

  // Number of chunks that make up one fragment.
  function automatic int nparts(input int frag_len, input int frag_part);
    return frag_len / frag_part;
  endfunction

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NPARTS = nparts(DEF_FRAG_LEN, DEF_FRAG_PART);

  // One completed group as stored in the output FIFO.
  typedef struct packed {
    logic                      clipped;
    logic [DEF_INDICE_LEN-1:0] index;
    logic [DEF_FRAG_LEN-1:0]   fragment;
  } gfm_group_t;

endpackage

// File: rtl/proj_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags.
// Latency: a written word is visible on rd_dat/rd_vld the cycle after the write.
// Backpressure: wr_rdy = ~full | pop; a write while full is accepted only alongside a pop.
//
// Ports: clk, rst_n (async active-low), wr_vld/wr_dat/wr_rdy (write side),
//        rd_vld/rd_dat/rd_rdy (read side, pop = rd_vld & rd_rdy), full, empty.
module proj_sync_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             wr_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  input  logic             rd_rdy,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             pop;
  logic             wr_acc;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign pop    = rd_rdy & ~empty;
  assign wr_rdy = ~full | pop;
  assign wr_acc = wr_vld & wr_rdy;

  // Outputs come straight from state (count, rd_ptr, mem): no input-to-output path.
  assign rd_vld = ~empty;
  assign rd_dat = mem[rd_ptr];

  // When full, wr_ptr == rd_ptr; a simultaneous push overwrites the slot being
  // popped, which is safe because the consumer takes the old word this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_acc) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(wr_acc) - CW'(pop);
    end
  end

endmodule

// File: rtl/proj_gfm_collector.sv
// Reassembles chunk beats into full fragments, clamps negative indices, queues groups.
// Latency: out_valid rises the cycle after the completing beat (FIFO empty case).
// Backpressure: none on input; a completed group meeting a full, non-popping FIFO is dropped (err_overflow).
//
// Ports: clk, rst_n; in_valid/in_index/in_gfm (free-running beats);
//        out_valid/out_ready/out_index/out_fragment/out_clipped (group stream);
//        err_overflow, err_mismatch (sticky until reset).
// Group field widths follow the package defaults, so width overrides belong in proj_pkg.
module proj_gfm_collector
  import proj_pkg::*;
#(
  parameter int FRAG_LEN          = DEF_FRAG_LEN,
  parameter int FRAG_PART         = DEF_FRAG_PART,
  parameter int INDICE_LEN        = DEF_INDICE_LEN,
  parameter int SIGNED_INDICE_LEN = DEF_SIGNED_INDICE_LEN,
  parameter int FIFO_DEPTH        = DEF_FIFO_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  input  logic signed [SIGNED_INDICE_LEN-1:0] in_index,
  input  logic        [FRAG_PART-1:0]         in_gfm,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic        [INDICE_LEN-1:0]        out_index,
  output logic        [FRAG_LEN-1:0]          out_fragment,
  output logic                                out_clipped,
  output logic                                err_overflow,
  output logic                                err_mismatch
);

  localparam int NPARTS = nparts(FRAG_LEN, FRAG_PART);
  localparam int CW     = cnt_width(NPARTS);

  logic        [CW-1:0]                cnt_q;
  logic signed [SIGNED_INDICE_LEN-1:0] idx_q;
  logic        [FRAG_LEN-1:0]          asm_q;

  logic                 mismatch;
  logic [CW-1:0]        k_eff;
  logic [FRAG_LEN-1:0]  frag_next;
  logic                 last_beat;
  gfm_group_t           grp_in;
  gfm_group_t           grp_out;
  logic                 fifo_wr_rdy;
  logic                 fifo_full;
  logic                 fifo_empty;

  always_comb begin
    mismatch  = 1'b0;
    k_eff     = cnt_q;
    frag_next = asm_q;
    last_beat = 1'b0;
    grp_in    = '0;

    // An index change mid-group abandons the partial group and restarts at chunk 0.
    mismatch = in_valid && (cnt_q != '0) && (in_index != idx_q);
    if (mismatch) begin
      k_eff = '0;
    end

    for (int k = 0; k < NPARTS; k++) begin
      if (k_eff == CW'(k)) begin
        frag_next[FRAG_PART*k +: FRAG_PART] = in_gfm;
      end
    end

    last_beat = in_valid && (k_eff == CW'(NPARTS - 1));

    // On the completing beat in_index equals the captured index (otherwise it
    // would have been a mismatch), so the live value is used directly.
    grp_in.clipped  = in_index[SIGNED_INDICE_LEN-1];
    grp_in.index    = grp_in.clipped ? '0 : in_index[INDICE_LEN-1:0];
    grp_in.fragment = frag_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      asm_q        <= '0;
      err_overflow <= 1'b0;
      err_mismatch <= 1'b0;
    end else begin
      if (in_valid) begin
        asm_q <= frag_next;
        if (k_eff == '0) begin
          idx_q <= in_index;
        end
        cnt_q <= last_beat ? '0 : k_eff + 1'b1;
      end
      if (mismatch) begin
        err_mismatch <= 1'b1;
      end
      if (last_beat && !fifo_wr_rdy) begin
        err_overflow <= 1'b1;
      end
    end
  end

  proj_sync_fifo #(
    .WIDTH ($bits(gfm_group_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (last_beat),
    .wr_dat (grp_in),
    .wr_rdy (fifo_wr_rdy),
    .rd_vld (out_valid),
    .rd_dat (grp_out),
    .rd_rdy (out_ready),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign out_index    = grp_out.index;
  assign out_fragment = grp_out.fragment;
  assign out_clipped  = grp_out.clipped;

endmodule

// File: tb/tb_proj_gfm_collector.sv
module tb_proj_gfm_collector;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [5:0] in_index = '0;
  logic        [1:0] in_gfm = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic        [4:0] out_index;
  logic        [7:0] out_fragment;
  logic              out_clipped;
  logic              err_overflow;
  logic              err_mismatch;

  proj_gfm_collector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_index     (in_index),
    .in_gfm       (in_gfm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_index    (out_index),
    .out_fragment (out_fragment),
    .out_clipped  (out_clipped),
    .err_overflow (err_overflow),
    .err_mismatch (err_mismatch)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: groups as plain integers, FIFO as a bounded queue of 4.
  typedef struct {
    int idx;
    bit clipped;
    int frag;
  } grp_t;

  grp_t exp_q[$];
  int   cur_chunks[$];
  int   cur_idx;
  bit   ovf_m;
  bit   mm_m;
  int   dut_pops;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() > 0});
    if (exp_q.size() > 0) begin
      chk("out_index", {27'b0, out_index}, exp_q[0].idx);
      chk("out_clipped", {31'b0, out_clipped}, {31'b0, exp_q[0].clipped});
      chk("out_fragment", {24'b0, out_fragment}, exp_q[0].frag);
    end
    chk("err_overflow", {31'b0, err_overflow}, {31'b0, ovf_m});
    chk("err_mismatch", {31'b0, err_mismatch}, {31'b0, mm_m});
  endtask

  // Called at a negedge; drives one cycle, advances the model, checks at next negedge.
  task automatic step(input bit v, input int idx, input int gfm, input bit rdy);
    bit   pop;
    bit   have;
    grp_t g;
    have = 1'b0;
    g = '{0, 1'b0, 0};
    in_valid  = v;
    in_index  = idx[5:0];
    in_gfm    = gfm[1:0];
    out_ready = rdy;
    pop = rdy && (exp_q.size() > 0);
    if (out_valid && out_ready) dut_pops++;
    if (v) begin
      if (cur_chunks.size() > 0 && idx != cur_idx) begin
        cur_chunks.delete();
        mm_m = 1'b1;
      end
      if (cur_chunks.size() == 0) cur_idx = idx;
      cur_chunks.push_back(gfm);
      if (cur_chunks.size() == 4) begin
        for (int k = 0; k < 4; k++) g.frag += cur_chunks[k] * (4 ** k);
        g.clipped = (cur_idx < 0);
        g.idx     = g.clipped ? 0 : cur_idx;
        have      = 1'b1;
        cur_chunks.delete();
      end
    end
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (have) begin
      if (exp_q.size() < 4) exp_q.push_back(g);
      else ovf_m = 1'b1;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_index", {27'b0, out_index}, 32'd0);
    chk("rst_out_fragment", {24'b0, out_fragment}, 32'd0);
    chk("rst_out_clipped", {31'b0, out_clipped}, 32'd0);
    chk("rst_err_overflow", {31'b0, err_overflow}, 32'd0);
    chk("rst_err_mismatch", {31'b0, err_mismatch}, 32'd0);
    exp_q.delete();
    cur_chunks.delete();
    ovf_m = 1'b0;
    mm_m  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int gi;
    // Reset state
    do_reset();

    // Basic group: index 5, chunks 01,10,11,00 -> 0x39
    step(1, 5, 1, 0);
    step(1, 5, 2, 0);
    step(1, 5, 3, 0);
    step(1, 5, 0, 0);
    chk("basic_valid", {31'b0, out_valid}, 32'd1);
    chk("basic_fragment", {24'b0, out_fragment}, 32'h39);
    chk("basic_index", {27'b0, out_index}, 32'd5);
    chk("basic_clipped", {31'b0, out_clipped}, 32'd0);
    step(0, 0, 0, 1);

    // Negative index: -2, chunks 3,2,1,0 -> 0x1B, clamped
    step(1, -2, 3, 1);
    step(1, -2, 2, 1);
    step(1, -2, 1, 1);
    step(1, -2, 0, 0);
    chk("neg_index", {27'b0, out_index}, 32'd0);
    chk("neg_clipped", {31'b0, out_clipped}, 32'd1);
    chk("neg_fragment", {24'b0, out_fragment}, 32'h1B);
    step(0, 0, 0, 1);

    // Overflow: 5 groups with no pops, then drain 4 in order
    for (int g = 0; g < 5; g++)
      for (int k = 0; k < 4; k++) step(1, g + 10, (g + k) % 4, 0);
    chk("ovf_flag", {31'b0, err_overflow}, 32'd1);
    chk("ovf_head_index", {27'b0, out_index}, 32'd10);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    chk("ovf_drained", {31'b0, out_valid}, 32'd0);

    // Simultaneous push on full FIFO with a pop in the same cycle
    do_reset();
    for (int g = 0; g < 4; g++)
      for (int k = 0; k < 4; k++) step(1, g + 20, k, 0);
    step(1, 24, 1, 0);
    step(1, 24, 1, 0);
    step(1, 24, 1, 0);
    step(1, 24, 1, 1);
    chk("sim_no_ovf", {31'b0, err_overflow}, 32'd0);
    chk("sim_head_index", {27'b0, out_index}, 32'd21);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    chk("sim_drained", {31'b0, out_valid}, 32'd0);

    // Mismatch: index 3 for 2 beats, then index 4 for 4 beats
    do_reset();
    dut_pops = 0;
    step(1, 3, 1, 0);
    step(1, 3, 2, 0);
    for (int k = 0; k < 4; k++) step(1, 4, 3 - k, 0);
    chk("mm_flag", {31'b0, err_mismatch}, 32'd1);
    chk("mm_index", {27'b0, out_index}, 32'd4);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    chk("mm_group_count", dut_pops, 32'd1);

    // Reset mid-group, then a clean group with index 7
    step(1, 6, 1, 0);
    step(1, 6, 2, 0);
    do_reset();
    for (int k = 0; k < 4; k++) step(1, 7, k, 0);
    chk("midrst_index", {27'b0, out_index}, 32'd7);
    chk("midrst_valid", {31'b0, out_valid}, 32'd1);
    step(0, 0, 0, 1);

    // Randomized traffic against the model
    do_reset();
    gi = 3;
    for (int i = 0; i < 800; i++) begin
      bit v;
      bit r;
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) gi = int'($urandom_range(0, 63)) - 32;
      r = ((i % 100) < 40) ? 1'b0 : 1'($urandom_range(0, 1));
      step(v, gi, int'($urandom_range(0, 3)), r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
